// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a BOOT/RUN/HALT control FSM.
//
// Drives a registered fetch address to a combinational instruction memory and
// latches the returned word into IR one cycle later, tagged with the address it
// came from. Redirect loads a new fetch address and flushes IR; Stall freezes
// all fetch state. A word whose top six bits equal HALT_OPCODE is passed to
// decode once and then the unit parks in HALT until Redirect or reset.
//
// Ports
//   Clock       in   rising-edge clock
//   Reset       in   synchronous, active-low reset
//   Instruction in   24-bit instruction-memory read data for address PC
//   Stall       in   hold all fetch state
//   Redirect    in   load PC from Target and flush IR (beats Stall)
//   Target      in   24-bit redirect address
//   PC          out  24-bit registered fetch address
//   IR          out  24-bit registered fetched instruction
//   IR_PC       out  24-bit address IR was fetched from
//   Valid       out  IR holds a real instruction
//   Halted      out  FSM is in HALT (registered)
module fetch_unit #(
  parameter logic [23:0] RESET_PC    = 24'h000000,
  parameter logic [23:0] PC_STEP     = 24'd1,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [23:0] Instruction,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [23:0] Target,
  output logic [23:0] PC,
  output logic [23:0] IR,
  output logic [23:0] IR_PC,
  output logic        Valid,
  output logic        Halted
);

  typedef enum logic [1:0] {
    StBoot = 2'b00,
    StRun  = 2'b01,
    StHalt = 2'b10
  } state_e;

  state_e state;
  logic   is_halt;

  assign is_halt = (Instruction[23:18] == HALT_OPCODE);

  // Halted is updated in lockstep with state so it always mirrors state==HALT
  // without any combinational path from Instruction.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state  <= StBoot;
      PC     <= RESET_PC;
      IR     <= 24'h000000;
      IR_PC  <= 24'h000000;
      Valid  <= 1'b0;
      Halted <= 1'b0;
    end else if (Redirect) begin
      // IR_PC deliberately untouched: IR is flushed so its tag is meaningless.
      state  <= StRun;
      PC     <= Target;
      IR     <= 24'h000000;
      Valid  <= 1'b0;
      Halted <= 1'b0;
    end else if (!Stall) begin
      unique case (state)
        StBoot: begin
          state  <= StRun;
          Valid  <= 1'b0;
          Halted <= 1'b0;
        end
        StRun: begin
          IR    <= Instruction;
          IR_PC <= PC;
          Valid <= 1'b1;
          if (is_halt) begin
            // PC stays on the halt word; nothing past it is fetched.
            state  <= StHalt;
            Halted <= 1'b1;
          end else begin
            PC <= PC + PC_STEP;
          end
        end
        StHalt: begin
          Valid <= 1'b0;
        end
        default: begin
          state  <= StBoot;
          Valid  <= 1'b0;
          Halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        Clock;
  logic        Reset;
  logic [23:0] Instruction;
  logic        Stall;
  logic        Redirect;
  logic [23:0] Target;
  logic [23:0] PC;
  logic [23:0] IR;
  logic [23:0] IR_PC;
  logic        Valid;
  logic        Halted;

  int tests_run    = 0;
  int tests_failed = 0;

  // Memory model: word at n is 010000+n, except one optional halt word.
  logic        halt_en   = 1'b0;
  logic [23:0] halt_addr = 24'h000000;

  always_comb begin
    Instruction = 24'h010000 + PC;
    if (halt_en && (PC == halt_addr)) Instruction = 24'hFC0000;
  end

  fetch_unit #(
    .RESET_PC   (24'h000000),
    .PC_STEP    (24'd1),
    .HALT_OPCODE(6'h3F)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Instruction(Instruction),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .Target     (Target),
    .PC         (PC),
    .IR         (IR),
    .IR_PC      (IR_PC),
    .Valid      (Valid),
    .Halted     (Halted)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // One cycle of stimulus and the expected outputs after its edge.
  typedef struct packed {
    logic        rst_n;
    logic        redir;
    logic        stall;
    logic [23:0] tgt;
    logic [23:0] pc;
    logic [23:0] ir;
    logic [23:0] ir_pc;
    logic        valid;
    logic        halted;
  } step_t;

  function automatic step_t mk(input logic rn, input logic rd, input logic st,
                               input logic [23:0] tg, input logic [23:0] pc,
                               input logic [23:0] ir, input logic [23:0] irpc,
                               input logic v, input logic h);
    step_t s;
    s.rst_n  = rn;
    s.redir  = rd;
    s.stall  = st;
    s.tgt    = tg;
    s.pc     = pc;
    s.ir     = ir;
    s.ir_pc  = irpc;
    s.valid  = v;
    s.halted = h;
    return s;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    step_t q[$];
    // Reset wins over Redirect and Stall.
    q.push_back(mk(0, 1, 1, 24'h123456, 24'h000000, 24'h000000, 24'h000000, 0, 0));
    q.push_back(mk(0, 0, 0, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 0, 0));
    foreach (q[i]) begin
      Reset = q[i].rst_n; Redirect = q[i].redir; Stall = q[i].stall; Target = q[i].tgt;
      tick();
      tests_run++;
      if ({PC, IR, IR_PC, Valid, Halted} !==
          {q[i].pc, q[i].ir, q[i].ir_pc, q[i].valid, q[i].halted}) begin
        tests_failed++;
        $display("FAIL reset step %0d: got PC=%h IR=%h IR_PC=%h V=%b H=%b, want PC=%h IR=%h IR_PC=%h V=%b H=%b",
                 i, PC, IR, IR_PC, Valid, Halted,
                 q[i].pc, q[i].ir, q[i].ir_pc, q[i].valid, q[i].halted);
      end
    end
  endtask

  task automatic test_boot_fetch();
    step_t q[$];
    q.push_back(mk(1, 0, 0, 0, 24'h000000, 24'h000000, 24'h000000, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 24'h000001, 24'h010000, 24'h000000, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 24'h000002, 24'h010001, 24'h000001, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 24'h000003, 24'h010002, 24'h000002, 1, 0));
    foreach (q[i]) begin
      Reset = q[i].rst_n; Redirect = q[i].redir; Stall = q[i].stall; Target = q[i].tgt;
      tick();
      tests_run++;
      if ({PC, IR, IR_PC, Valid, Halted} !==
          {q[i].pc, q[i].ir, q[i].ir_pc, q[i].valid, q[i].halted}) begin
        tests_failed++;
        $display("FAIL boot_fetch step %0d: got PC=%h IR=%h IR_PC=%h V=%b H=%b, want PC=%h IR=%h IR_PC=%h V=%b H=%b",
                 i, PC, IR, IR_PC, Valid, Halted,
                 q[i].pc, q[i].ir, q[i].ir_pc, q[i].valid, q[i].halted);
      end
    end
  endtask

  task automatic test_stall();
    step_t q[$];
    q.push_back(mk(1, 0, 0, 0, 24'h000004, 24'h010003, 24'h000003, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 24'h000005, 24'h010004, 24'h000004, 1, 0));
    for (int k = 0; k < 3; k++)
      q.push_back(mk(1, 0, 1, 0, 24'h000005, 24'h010004, 24'h000004, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 24'h000006, 24'h010005, 24'h000005, 1, 0));
    foreach (q[i]) begin
      Reset = q[i].rst_n; Redirect = q[i].redir; Stall = q[i].stall; Target = q[i].tgt;
      tick();
      tests_run++;
      if ({PC, IR, IR_PC, Valid, Halted} !==
          {q[i].pc, q[i].ir, q[i].ir_pc, q[i].valid, q[i].halted}) begin
        tests_failed++;
        $display("FAIL stall step %0d: got PC=%h IR=%h IR_PC=%h V=%b H=%b, want PC=%h IR=%h IR_PC=%h V=%b H=%b",
                 i, PC, IR, IR_PC, Valid, Halted,
                 q[i].pc, q[i].ir, q[i].ir_pc, q[i].valid, q[i].halted);
      end
    end
  endtask

  task automatic test_redirect();
    step_t q[$];
    q.push_back(mk(1, 0, 0, 0, 24'h000007, 24'h010006, 24'h000006, 1, 0));
    // Redirect with Stall behaves as Redirect; IR_PC keeps its old value.
    q.push_back(mk(1, 1, 1, 24'h000A00, 24'h000A00, 24'h000000, 24'h000006, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 24'h000A01, 24'h010A00, 24'h000A00, 1, 0));
    foreach (q[i]) begin
      Reset = q[i].rst_n; Redirect = q[i].redir; Stall = q[i].stall; Target = q[i].tgt;
      tick();
      tests_run++;
      if ({PC, IR, IR_PC, Valid, Halted} !==
          {q[i].pc, q[i].ir, q[i].ir_pc, q[i].valid, q[i].halted}) begin
        tests_failed++;
        $display("FAIL redirect step %0d: got PC=%h IR=%h IR_PC=%h V=%b H=%b, want PC=%h IR=%h IR_PC=%h V=%b H=%b",
                 i, PC, IR, IR_PC, Valid, Halted,
                 q[i].pc, q[i].ir, q[i].ir_pc, q[i].valid, q[i].halted);
      end
    end
  endtask

  task automatic test_halt();
    step_t q[$];
    halt_en   = 1'b1;
    halt_addr = 24'h000009;
    q.push_back(mk(1, 1, 0, 24'h000005, 24'h000005, 24'h000000, 24'h000A00, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 24'h000006, 24'h010005, 24'h000005, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 24'h000007, 24'h010006, 24'h000006, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 24'h000008, 24'h010007, 24'h000007, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 24'h000009, 24'h010008, 24'h000008, 1, 0));
    // Halt word on the bus while stalled: nothing happens yet.
    for (int k = 0; k < 2; k++)
      q.push_back(mk(1, 0, 1, 0, 24'h000009, 24'h010008, 24'h000008, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 24'h000009, 24'hFC0000, 24'h000009, 1, 1));
    for (int k = 0; k < 10; k++)
      q.push_back(mk(1, 0, 0, 0, 24'h000009, 24'hFC0000, 24'h000009, 0, 1));
    q.push_back(mk(1, 1, 0, 24'h000020, 24'h000020, 24'h000000, 24'h000009, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 24'h000021, 24'h010020, 24'h000020, 1, 0));
    foreach (q[i]) begin
      Reset = q[i].rst_n; Redirect = q[i].redir; Stall = q[i].stall; Target = q[i].tgt;
      tick();
      tests_run++;
      if ({PC, IR, IR_PC, Valid, Halted} !==
          {q[i].pc, q[i].ir, q[i].ir_pc, q[i].valid, q[i].halted}) begin
        tests_failed++;
        $display("FAIL halt step %0d: got PC=%h IR=%h IR_PC=%h V=%b H=%b, want PC=%h IR=%h IR_PC=%h V=%b H=%b",
                 i, PC, IR, IR_PC, Valid, Halted,
                 q[i].pc, q[i].ir, q[i].ir_pc, q[i].valid, q[i].halted);
      end
    end
    halt_en = 1'b0;
  endtask

  task automatic test_wrap();
    step_t q[$];
    q.push_back(mk(1, 1, 0, 24'hFFFFFE, 24'hFFFFFE, 24'h000000, 24'h000020, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 24'hFFFFFF, 24'h00FFFE, 24'hFFFFFE, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 24'h000000, 24'h00FFFF, 24'hFFFFFF, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 24'h000001, 24'h010000, 24'h000000, 1, 0));
    foreach (q[i]) begin
      Reset = q[i].rst_n; Redirect = q[i].redir; Stall = q[i].stall; Target = q[i].tgt;
      tick();
      tests_run++;
      if ({PC, IR, IR_PC, Valid, Halted} !==
          {q[i].pc, q[i].ir, q[i].ir_pc, q[i].valid, q[i].halted}) begin
        tests_failed++;
        $display("FAIL wrap step %0d: got PC=%h IR=%h IR_PC=%h V=%b H=%b, want PC=%h IR=%h IR_PC=%h V=%b H=%b",
                 i, PC, IR, IR_PC, Valid, Halted,
                 q[i].pc, q[i].ir, q[i].ir_pc, q[i].valid, q[i].halted);
      end
    end
  endtask

  task automatic test_reset_in_halt();
    step_t q[$];
    halt_en   = 1'b1;
    halt_addr = 24'h000009;
    q.push_back(mk(1, 1, 0, 24'h000009, 24'h000009, 24'h000000, 24'h000000, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 24'h000009, 24'hFC0000, 24'h000009, 1, 1));
    q.push_back(mk(1, 0, 0, 0, 24'h000009, 24'hFC0000, 24'h000009, 0, 1));
    q.push_back(mk(0, 0, 1, 0, 24'h000000, 24'h000000, 24'h000000, 0, 0));
    // Stall right after release holds the unit in BOOT.
    q.push_back(mk(1, 0, 1, 0, 24'h000000, 24'h000000, 24'h000000, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 24'h000000, 24'h000000, 24'h000000, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 24'h000001, 24'h010000, 24'h000000, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 24'h000002, 24'h010001, 24'h000001, 1, 0));
    foreach (q[i]) begin
      Reset = q[i].rst_n; Redirect = q[i].redir; Stall = q[i].stall; Target = q[i].tgt;
      tick();
      tests_run++;
      if ({PC, IR, IR_PC, Valid, Halted} !==
          {q[i].pc, q[i].ir, q[i].ir_pc, q[i].valid, q[i].halted}) begin
        tests_failed++;
        $display("FAIL reset_in_halt step %0d: got PC=%h IR=%h IR_PC=%h V=%b H=%b, want PC=%h IR=%h IR_PC=%h V=%b H=%b",
                 i, PC, IR, IR_PC, Valid, Halted,
                 q[i].pc, q[i].ir, q[i].ir_pc, q[i].valid, q[i].halted);
      end
    end
    halt_en = 1'b0;
  endtask

  initial begin
    Reset    = 1'b0;
    Stall    = 1'b0;
    Redirect = 1'b0;
    Target   = 24'h000000;
    test_reset();
    test_boot_fetch();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_in_halt();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
- REQ-001: Parameter RESET_PC, default 24'h000000, SHALL be the PC value loaded at reset.
- REQ-002: Parameter PC_STEP, default 24'd1, SHALL be the PC increment per fetched instruction.
- REQ-003: Parameter HALT_OPCODE, default 6'h3F, SHALL be the value of Instruction[23:18] that marks a halt instruction.
- REQ-004: Port Clock, input, 1 bit, SHALL be the single clock; all state updates happen on its rising edge.
- REQ-005: Port Reset, input, 1 bit, SHALL be the reset; it is synchronous and active-low.
- REQ-006: Port Instruction, input, 24 bits, SHALL carry the combinational instruction-memory read data for address PC.
- REQ-007: Port Stall, input, 1 bit, SHALL request that all fetch state be held.
- REQ-008: Port Redirect, input, 1 bit, SHALL request a taken branch or jump to Target.
- REQ-009: Port Target, input, 24 bits, SHALL carry the redirect address, sampled only when Redirect=1.
- REQ-010: Port PC, output, 24 bits, SHALL be the registered fetch address driven to instruction memory.
- REQ-011: Port IR, output, 24 bits, SHALL be the registered fetched instruction passed to decode.
- REQ-012: Port IR_PC, output, 24 bits, SHALL be the address from which IR was fetched.
- REQ-013: Port Valid, output, 1 bit, SHALL be 1 when IR holds a real instruction for decode.
- REQ-014: Port Halted, output, 1 bit, SHALL be 1 while the FSM is in HALT.

Function
- REQ-015: The FSM SHALL have exactly three states: BOOT, RUN and HALT.
- REQ-016: Edge priority SHALL be Reset, then Redirect, then Stall, then normal operation.
- REQ-017: BOOT SHALL last exactly one cycle, perform no fetch, hold Valid=0, and go to RUN.
- REQ-018: In RUN with no Redirect, no Stall and a non-halt instruction, each edge SHALL set IR<=Instruction, IR_PC<=PC, Valid<=1 and PC<=PC+PC_STEP.
- REQ-019: The PC addition SHALL be 24-bit modulo, so 24'hFFFFFF+1 wraps to 24'h000000 with no flag and no state change.
- REQ-020: Fetch-to-IR latency SHALL be one cycle: the instruction at address A appears on IR the edge after PC=A.
- REQ-021: Stall=1 (without Redirect) SHALL hold PC, IR, IR_PC, Valid and state unchanged, in every state.
- REQ-022: Redirect=1 SHALL, from any state, set PC<=Target, IR<=24'h000000, Valid<=0, and state<=RUN, leaving IR_PC unchanged.
- REQ-023: Redirect and Stall asserted together SHALL behave as Redirect alone.
- REQ-024: In RUN with no Redirect and no Stall, Instruction[23:18]==HALT_OPCODE SHALL set IR<=Instruction, IR_PC<=PC, Valid<=1, hold PC, and go to HALT.
- REQ-025: In HALT, the first edge SHALL drop Valid to 0, and PC, IR and IR_PC SHALL then hold until Redirect or reset.
- REQ-026: The halt instruction SHALL be presented with Valid=1 for exactly one cycle.
- REQ-027: Halted SHALL equal (state==HALT) and be registered, never combinational from Instruction.
- REQ-028: Stall arriving in the same cycle as a halt instruction SHALL win, deferring halt detection until Stall drops.

Reset
- REQ-029: An edge with Reset=0 SHALL set PC=RESET_PC, IR=24'h000000, IR_PC=24'h000000, Valid=0, Halted=0 and state=BOOT, regardless of Stall, Redirect or state.
- REQ-030: Reset asserted mid-operation, including in HALT, SHALL abandon the in-flight IR, and no Valid=1 pulse SHALL appear until two edges after Reset returns to 1.

Verification (RESET_PC=0, PC_STEP=1, HALT_OPCODE=6'h3F, memory word at address n = 24'h010000+n unless noted)
- REQ-031: Release reset, run 4 edges -> PC sequence 0 (BOOT), 1, 2, 3; IR/IR_PC = 010000/0, then 010001/1, then 010002/2; Valid rises on the 2nd edge after release.
- REQ-032: In RUN at PC=5, Stall=1 for 3 cycles -> PC=5, IR=010004, IR_PC=4, Valid=1 held for all 3 cycles; the edge after release gives IR=010005.
- REQ-033: At PC=7, Redirect=1 with Target=24'h000A00 and Stall=1 -> next cycle PC=A00, Valid=0, IR=0; the following edge gives IR_PC=A00.
- REQ-034: Word at address 9 = 24'hFC0000, normal run -> IR=FC0000, IR_PC=9, Valid=1 for one cycle; then Halted=1, Valid=0, PC=9 held for 10 cycles; Redirect to 0x20 -> Halted=0, fetch resumes at 0x20.
- REQ-035: Redirect to 24'hFFFFFE, run 3 edges -> PC sequence FFFFFE, FFFFFF, 000000, with IR_PC following one cycle behind.
- REQ-036: Reset=0 for one edge while in HALT -> PC=0, Valid=0, Halted=0, state BOOT; normal fetch from 0 resumes as in REQ-031.
